// File: rtl/load_issue_pkg.sv
// +----------------------------------------------------------------------------+
// | load_issue_pkg                                                             |
// | Shared FSM state encoding and funct3 load-size constants for load_issue.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package load_issue_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/load_issue_align.sv
// +----------------------------------------------------------------------------+
// | load_align                                                                 |
// | Extracts/extends the loaded byte, halfword or word and flags bad loads.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_align
    import load_issue_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data,
    output logic        o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_data = '0;
        o_err  = 1'b0;
        case (i_funct3)
            c_F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LBU: o_data = {24'h0, w_byte};
            c_F3_LH: begin
                o_data = {{16{w_half[15]}}, w_half};
                o_err  = i_addr_lo[0];
            end
            c_F3_LHU: begin
                o_data = {16'h0, w_half};
                o_err  = i_addr_lo[0];
            end
            c_F3_LW: begin
                o_data = i_rdata;
                o_err  = |i_addr_lo;
            end
            default: o_err = 1'b1;  // 011, 110, 111 are not loads
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_issue.sv
// +----------------------------------------------------------------------------+
// | load_issue                                                                 |
// | Pops one resolved load, issues a single cache request, writes back result. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_issue
    import load_issue_pkg::*;
#(
    parameter int WIDTH_ADDR = 32,
    parameter int WIDTH_REG  = 5,
    parameter int WIDTH_TAG  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_empty,
    input  logic                  i_A,
    input  logic [WIDTH_ADDR-1:0] i_addr,
    input  logic [WIDTH_REG-1:0]  i_rd,
    input  logic [WIDTH_TAG-1:0]  i_tag,
    input  logic [2:0]            i_funct3,
    output logic                  o_re,
    output logic                  o_mem_req,
    output logic [WIDTH_ADDR-1:0] o_mem_addr,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [31:0]           i_mem_rdata,
    input  logic                  i_kill,
    input  logic                  i_wb_ready,
    output logic                  o_wb_valid,
    output logic [WIDTH_REG-1:0]  o_wb_rd,
    output logic [WIDTH_TAG-1:0]  o_wb_tag,
    output logic [31:0]           o_wb_data,
    output logic                  o_wb_err
);

    state_t                r_state;
    state_t                w_next;
    logic [WIDTH_ADDR-1:0] r_addr;
    logic [WIDTH_REG-1:0]  r_rd;
    logic [WIDTH_TAG-1:0]  r_tag;
    logic [2:0]            r_funct3;
    logic [31:0]           r_data;
    logic                  r_err;

    logic                  w_pop;
    logic                  w_capture;
    logic [1:0]            w_al_lo;
    logic [2:0]            w_al_f3;
    logic [31:0]           w_al_data;
    logic                  w_al_err;

    // In IDLE the aligner checks the queue head; elsewhere it formats the latched load.
    assign w_al_lo = (r_state == S_IDLE) ? i_addr[1:0] : r_addr[1:0];
    assign w_al_f3 = (r_state == S_IDLE) ? i_funct3    : r_funct3;

    load_align u_align (
        .i_rdata   (i_mem_rdata),
        .i_addr_lo (w_al_lo),
        .i_funct3  (w_al_f3),
        .o_data    (w_al_data),
        .o_err     (w_al_err)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_rd     <= '0;
            r_tag    <= '0;
            r_funct3 <= '0;
            r_data   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                r_addr   <= i_addr;
                r_rd     <= i_rd;
                r_tag    <= i_tag;
                r_funct3 <= i_funct3;
                r_err    <= w_al_err;
                r_data   <= '0;
            end
            if (w_capture) begin
                r_data <= w_al_data;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!i_empty && i_A && !i_kill) begin
                    w_pop  = 1'b1;
                    w_next = w_al_err ? S_WB : S_REQ;
                end
            end
            S_REQ: begin
                // A grant coinciding with a kill still leaves a response in flight.
                if (i_kill)         w_next = i_mem_gnt ? S_DRAIN : S_IDLE;
                else if (i_mem_gnt) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_kill) begin
                    w_next = i_mem_rvalid ? S_IDLE : S_DRAIN;
                end else if (i_mem_rvalid) begin
                    w_capture = 1'b1;
                    w_next    = S_WB;
                end
            end
            S_WB: begin
                if (i_kill || i_wb_ready) w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (i_mem_rvalid) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_re       = w_pop & ~i_rst;
    assign o_mem_req  = (r_state == S_REQ) & ~i_kill & ~i_rst;
    assign o_mem_addr = ((r_state == S_REQ) && !i_rst) ? {r_addr[WIDTH_ADDR-1:2], 2'b00} : '0;
    assign o_wb_valid = (r_state == S_WB) & ~i_kill & ~i_rst;
    assign o_wb_rd    = i_rst ? '0 : r_rd;
    assign o_wb_tag   = i_rst ? '0 : r_tag;
    assign o_wb_data  = i_rst ? '0 : r_data;
    assign o_wb_err   = r_err & ~i_rst;

endmodule

`default_nettype wire
